// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit with HI/LO registers.
// One bit per clock: shift-add multiply and restoring divide on operand
// magnitudes, with sign correction applied in the final cycle. HI/LO are
// also writable directly (MTHI/MTLO) while the unit is idle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]         state_reg;
  logic [CW-1:0]      cnt_reg;
  logic               is_div_reg;
  logic               sign_a_reg;
  logic               sign_b_reg;
  logic [WIDTH-1:0]   a_orig_reg;
  logic [WIDTH-1:0]   opnd_reg;     // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_reg;      // {product high, multiplier} or {remainder, quotient}
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic               done_reg;
  logic               dbz_reg;

  // op[0] == 0 selects the signed variants
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;

  logic               res_neg;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   fin_hi;
  logic [WIDTH-1:0]   fin_lo;
  logic               fin_dbz;

  assign a_neg = ~op[0] & a[WIDTH-1];
  assign b_neg = ~op[0] & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // Shift-add step: conditionally add multiplicand to the upper half, then shift right.
  // Restoring step: shift in next dividend bit, subtract divisor unless it borrows.
  // With a non-zero divisor the partial remainder stays below it, so bit WIDTH of
  // the difference is a clean borrow flag.
  always_comb begin
    mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    mul_next = {mul_sum, acc_reg[WIDTH-1:1]};
    div_diff = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]} - {1'b0, opnd_reg};
    if (div_diff[WIDTH])
      div_next = {acc_reg[2*WIDTH-2:0], 1'b0};
    else
      div_next = {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
  end

  // Sign correction and the divide-by-zero override, evaluated during FIN.
  always_comb begin
    res_neg  = sign_a_reg ^ sign_b_reg;
    prod_fix = res_neg ? -acc_reg : acc_reg;
    quo_fix  = res_neg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    rem_fix  = sign_a_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
    fin_dbz  = is_div_reg && (opnd_reg == '0);
    if (!is_div_reg) begin
      fin_hi = prod_fix[2*WIDTH-1:WIDTH];
      fin_lo = prod_fix[WIDTH-1:0];
    end else if (fin_dbz) begin
      fin_hi = a_orig_reg;
      fin_lo = '1;
    end else begin
      fin_hi = rem_fix;
      fin_lo = quo_fix;
    end
  end

  // Sequencer and iteration datapath: launch in IDLE, WIDTH steps in RUN, publish in FIN.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      is_div_reg <= 1'b0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      a_orig_reg <= '0;
      opnd_reg   <= '0;
      acc_reg    <= '0;
      done_reg   <= 1'b0;
      dbz_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      dbz_reg  <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg  <= S_RUN;
            cnt_reg    <= CW'(WIDTH);
            is_div_reg <= op[1];
            sign_a_reg <= a_neg;
            sign_b_reg <= b_neg;
            a_orig_reg <= a;
            opnd_reg   <= op[1] ? b_mag : a_mag;
            acc_reg    <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
          end
        end
        S_RUN: begin
          acc_reg <= is_div_reg ? div_next : mul_next;
          cnt_reg <= (cnt_reg != '0) ? cnt_reg - CW'(1) : '0;
          if (cnt_reg <= CW'(1))
            state_reg <= S_FIN;
        end
        S_FIN: begin
          state_reg <= S_IDLE;
          done_reg  <= 1'b1;
          dbz_reg   <= fin_dbz;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Architectural HI/LO: results at FIN, MTHI/MTLO only while idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (state_reg == S_FIN) begin
      hi_reg <= fin_hi;
      lo_reg <= fin_lo;
    end else if (state_reg == S_IDLE) begin
      if (hi_we) hi_reg <= wd;
      if (lo_we) lo_reg <= wd;
    end
  end

  assign busy        = (state_reg != S_IDLE);
  assign done        = done_reg;
  assign div_by_zero = dbz_reg;
  assign hi          = hi_reg;
  assign lo          = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: table of operations plus hand-written sequences
// for busy timing, back-to-back launch, MTHI/MTLO and reset abort.
module tb_muldiv_unit;

  localparam int W = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wd;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } vec_t;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           due;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[10];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wd(wd), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: 0x%08h (cycle %0d)", name, act, cyc);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest launched operation.
  always begin
    exp_t e;
    @(posedge clock);
    #1;
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("res_hi", hi, e.hi);
        check("res_lo", lo, e.lo);
        check("res_dbz", W'(div_by_zero), W'(e.dbz));
        check("latency", W'(cyc), W'(e.due));
      end
    end
  end

  // Drive start for one cycle from the current negedge and record the expectation.
  task automatic launch(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edbz);
    exp_t e;
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    e.hi  = ehi;
    e.lo  = elo;
    e.dbz = edbz;
    e.due = cyc + W + 2;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    op    = 2'($urandom_range(3));
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0 pending", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wd = '0;

    vecs[0] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[1] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[2] = '{OP_DIVU,  32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1};
    vecs[3] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[4] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    vecs[5] = '{OP_MULT,  32'hFFFFFFFC, 32'hFFFFFFFA, 32'd0,        32'd24,       1'b0};
    vecs[6] = '{OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[7] = '{OP_MULTU, 32'h80000000, 32'd2,        32'd1,        32'd0,        1'b0};
    vecs[8] = '{OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0};
    vecs[9] = '{OP_DIV,   32'd5,        32'hFFFFFFF9, 32'd5,        32'd0,        1'b0};

    repeat (3) @(negedge clock);
    check("rst_busy", W'(busy), '0);
    check("rst_done", W'(done), '0);
    check("rst_dbz", W'(div_by_zero), '0);
    check("rst_hi", hi, '0);
    check("rst_lo", lo, '0);
    reset = 1'b0;

    // MULT -3 x 5 with the busy window checked cycle by cycle
    @(negedge clock);
    launch(OP_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    for (int i = 1; i <= W + 2; i++) begin
      if (i > 1) @(negedge clock);
      check($sformatf("busy_c%0d", i), W'(busy), W'(i <= W + 1));
    end
    wait_drain(W + 8);

    // MULTU all-ones squared, then a second launch in its done cycle
    @(negedge clock);
    launch(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    repeat (W + 1) @(negedge clock);
    check("b2b_done_cycle", W'(done), 32'd1);
    check("b2b_busy_low", W'(busy), '0);
    launch(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    wait_drain(2 * W + 8);

    // table of operations
    for (int v = 0; v < 10; v++) begin
      @(negedge clock);
      launch(vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].hi, vecs[v].lo, vecs[v].dbz);
      wait_drain(W + 8);
    end

    // MTHI alone, then MTHI and MTLO together
    @(negedge clock);
    hi_we = 1'b1; wd = 32'h12345678;
    @(negedge clock);
    hi_we = 1'b0;
    check("mthi", hi, 32'h12345678);
    hi_we = 1'b1; lo_we = 1'b1; wd = 32'hA5A5A5A5;
    @(negedge clock);
    hi_we = 1'b0; lo_we = 1'b0;
    check("mthi_both", hi, 32'hA5A5A5A5);
    check("mtlo_both", lo, 32'hA5A5A5A5);

    // start and MTHI in the same idle cycle: write lands, then the result overwrites it
    hi_we = 1'b1; wd = 32'h0BADF00D;
    launch(OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
    hi_we = 1'b0;
    check("start_with_mthi", hi, 32'h0BADF00D);
    wait_drain(W + 8);

    // writes and a second start while busy are ignored
    @(negedge clock);
    launch(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    repeat (4) @(negedge clock);
    hi_we = 1'b1; lo_we = 1'b1; wd = 32'hDEADBEEF;
    start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd3;
    @(negedge clock);
    hi_we = 1'b0; lo_we = 1'b0; start = 1'b0;
    check("busy_mthi_ignored", hi, 32'h40000000);
    check("busy_mtlo_ignored", lo, 32'h00000000);
    wait_drain(W + 8);
    repeat (W + 4) @(negedge clock);

    // reset in cycle 10 of a MULT aborts it with no done pulse
    @(negedge clock);
    launch(OP_MULT, 32'h00001234, 32'h00000010, 32'h0, 32'h00012340, 1'b0);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    #1;
    check("abort_busy", W'(busy), '0);
    check("abort_hi", hi, '0);
    check("abort_lo", lo, '0);
    sb.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    check("post_abort_busy", W'(busy), '0);
    launch(OP_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
    wait_drain(W + 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
